// File: rtl/m_rf_scoreboard.sv
// Integer register file with x0 = 0, two combinational read ports, one write port, and optional write-to-read bypass.
// Tracks pending writes per register and sets a sticky halt flag. Reads take 0 cycles, updates take 1 cycle, and there is no backpressure.
module m_rf_scoreboard #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int BYPASS   = 1,
  parameter int HALT_EN  = 1,
  parameter int HALT_REG = 30,
  localparam int AW      = $clog2(NREG)
) (
  input  logic            w_clk,
  input  logic            w_rst_n,
  input  logic [AW-1:0]   w_ra1,
  input  logic [AW-1:0]   w_ra2,
  output logic [XLEN-1:0] w_rd1,
  output logic [XLEN-1:0] w_rd2,
  input  logic            w_we,
  input  logic [AW-1:0]   w_wa,
  input  logic [XLEN-1:0] w_wd,
  input  logic            w_sb_set,
  input  logic [AW-1:0]   w_sb_wa,
  output logic            w_busy1,
  output logic            w_busy2,
  output logic            w_halt
);

  localparam logic [AW-1:0] HALT_IDX = AW'(HALT_REG);

  logic [XLEN-1:0] mem_q [NREG];
  logic [NREG-1:0] sb_q, sb_d;
  logic            halt_q, halt_d;
  logic            byp1, byp2;

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else if (w_we && (w_wa != '0)) begin
      mem_q[w_wa] <= w_wd;
    end
  end

  // Set is applied after clear so a newly issued producer wins over a retiring one.
  always_comb begin
    sb_d = sb_q;
    if (w_we) sb_d[w_wa] = 1'b0;
    if (w_sb_set && (w_sb_wa != '0)) sb_d[w_sb_wa] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_comb begin
    halt_d = halt_q;
    if ((HALT_EN != 0) && w_we && (w_wa == HALT_IDX)) halt_d = 1'b1;
  end

  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      sb_q   <= '0;
      halt_q <= 1'b0;
    end else begin
      sb_q   <= sb_d;
      halt_q <= halt_d;
    end
  end

  assign byp1 = (BYPASS != 0) && w_we && (w_wa == w_ra1);
  assign byp2 = (BYPASS != 0) && w_we && (w_wa == w_ra2);

  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (w_ra1 != '0) w_rd1 = byp1 ? w_wd : mem_q[w_ra1];
    if (w_ra2 != '0) w_rd2 = byp2 ? w_wd : mem_q[w_ra2];
  end

  assign w_busy1 = (w_ra1 != '0) && sb_q[w_ra1] && !byp1;
  assign w_busy2 = (w_ra2 != '0) && sb_q[w_ra2] && !byp2;
  assign w_halt  = halt_q;

endmodule

// File: tb/tb_m_rf_scoreboard.sv
// Directed bench: one default instance (bypass and halt enabled) and one instance with bypass and halt disabled.
// Both instances receive the same stimulus, and each result is compared against a value computed by hand.
module tb_m_rf_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa, sb_wa;
  logic [31:0] wd;
  logic        we, sb_set;
  logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
  logic        busy1_a, busy2_a, halt_a, busy1_b, busy2_b, halt_b;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  m_rf_scoreboard u_a (
    .w_clk(clk), .w_rst_n(rst_n), .w_ra1(ra1), .w_ra2(ra2), .w_rd1(rd1_a), .w_rd2(rd2_a),
    .w_we(we), .w_wa(wa), .w_wd(wd), .w_sb_set(sb_set), .w_sb_wa(sb_wa),
    .w_busy1(busy1_a), .w_busy2(busy2_a), .w_halt(halt_a)
  );

  m_rf_scoreboard #(.BYPASS(0), .HALT_EN(0)) u_b (
    .w_clk(clk), .w_rst_n(rst_n), .w_ra1(ra1), .w_ra2(ra2), .w_rd1(rd1_b), .w_rd2(rd2_b),
    .w_we(we), .w_wa(wa), .w_wd(wd), .w_sb_set(sb_set), .w_sb_wa(sb_wa),
    .w_busy1(busy1_b), .w_busy2(busy2_b), .w_halt(halt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; sb_set = 1'b0; sb_wa = '0;
    #12 rst_n = 1'b1;
    #1;

    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      #1;
      chk("rst_rd1_a", rd1_a, 0);
      chk("rst_rd2_a", rd2_a, 0);
      chk("rst_rd1_b", rd1_b, 0);
      chk("rst_busy", {busy1_a, busy2_a, busy1_b, busy2_b}, 0);
    end
    chk("rst_halt", {halt_a, halt_b}, 0);

    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF;
    tick();
    we = 1'b0; ra1 = 5'd5;
    #1;
    chk("wr_x5_a", rd1_a, 32'hDEADBEEF);
    chk("wr_x5_b", rd1_b, 32'hDEADBEEF);
    we = 1'b1; wa = 5'd0; wd = 32'h1234; ra1 = 5'd0;
    #1;
    chk("x0_byp_a", rd1_a, 0);
    tick();
    we = 1'b0;
    #1;
    chk("x0_a", rd1_a, 0);
    chk("x0_b", rd1_b, 0);

    we = 1'b1; wa = 5'd7; wd = 32'h11;
    tick();
    wd = 32'h55; ra2 = 5'd7;
    #1;
    chk("byp_on", rd2_a, 32'h55);
    chk("byp_off", rd2_b, 32'h11);
    tick();
    we = 1'b0;
    #1;
    chk("after_byp_a", rd2_a, 32'h55);
    chk("after_byp_b", rd2_b, 32'h55);

    sb_set = 1'b1; sb_wa = 5'd3;
    tick();
    sb_set = 1'b0; ra1 = 5'd3;
    #1;
    chk("sb_busy_a", busy1_a, 1);
    chk("sb_busy_b", busy1_b, 1);
    chk("sb_other", busy2_a, 0);
    we = 1'b1; wa = 5'd3; wd = 32'h33;
    #1;
    chk("wb_busy_a", busy1_a, 0);
    chk("wb_busy_b", busy1_b, 1);
    chk("wb_rd_a", rd1_a, 32'h33);
    tick();
    we = 1'b0;
    #1;
    chk("clr_busy_a", busy1_a, 0);
    chk("clr_busy_b", busy1_b, 0);
    chk("clr_rd_b", rd1_b, 32'h33);
    sb_set = 1'b1; sb_wa = 5'd3;
    tick();
    we = 1'b1; wa = 5'd3; wd = 32'h44;
    #1;
    chk("setclr_cyc_a", busy1_a, 0);
    chk("setclr_cyc_b", busy1_b, 1);
    tick();
    we = 1'b0; sb_set = 1'b0;
    #1;
    chk("setwins_a", busy1_a, 1);
    chk("setwins_b", busy1_b, 1);
    chk("setwins_rd", rd1_a, 32'h44);
    sb_set = 1'b1; sb_wa = 5'd3;
    tick();
    sb_set = 1'b0; we = 1'b1; wa = 5'd3; wd = 32'h45;
    tick();
    we = 1'b0;
    #1;
    chk("single_prod_a", busy1_a, 0);
    chk("single_prod_b", busy1_b, 0);
    sb_set = 1'b1; sb_wa = 5'd0; ra2 = 5'd0;
    tick();
    sb_set = 1'b0;
    #1;
    chk("sb_x0", busy2_a, 0);

    we = 1'b1; wa = 5'd30; wd = 32'h1;
    #1;
    chk("halt_pre", halt_a, 0);
    tick();
    we = 1'b0; ra1 = 5'd30;
    #1;
    chk("halt_a", halt_a, 1);
    chk("halt_dis_b", halt_b, 0);
    chk("halt_wr_b", rd1_b, 32'h1);
    tick();
    tick();
    chk("halt_held", halt_a, 1);
    we = 1'b1; wa = 5'd9; wd = 32'h99;
    tick();
    we = 1'b0; ra2 = 5'd9;
    #1;
    chk("post_halt_wr", rd2_a, 32'h99);
    chk("halt_still", halt_a, 1);

    sb_set = 1'b1; sb_wa = 5'd4;
    tick();
    sb_set = 1'b0; ra1 = 5'd5; ra2 = 5'd4;
    #1;
    chk("pre_rst_busy", busy2_a, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_rd_a", rd1_a, 0);
    chk("arst_rd_b", rd1_b, 0);
    chk("arst_busy", {busy2_a, busy2_b}, 0);
    chk("arst_halt", halt_a, 0);
    we = 1'b1; wa = 5'd6; wd = 32'h66;
    tick();
    #2 rst_n = 1'b1;
    we = 1'b0; ra1 = 5'd6;
    #1;
    chk("rst_drops_wr", rd1_a, 0);
    chk("rst_drops_wr_b", rd1_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
